// File: rtl/writeback_arbiter_pkg.sv
// Shared widths and types for the writeback arbiter slice.
//   REG_SIZE       register-address width
//   WORD_WIDTH     register data width
//   ZERO_WORD      all-zero data word
//   MD_FIFO_DEPTH  default multiply/divide result buffer depth
//   wb_src_e       source currently driving the register-file write port
package writeback_arbiter_pkg;

  localparam int unsigned REG_SIZE      = 5;
  localparam int unsigned WORD_WIDTH    = 32;
  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;
  localparam int unsigned MD_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    WB_SRC_NONE = 2'd0,
    WB_SRC_PIPE = 2'd1,
    WB_SRC_FIFO = 2'd2
  } wb_src_e;

  // Pipeline always wins; the buffer drains only into idle write slots.
  function automatic wb_src_e wb_select(input logic in_reset,
                                        input logic pipe_we,
                                        input logic fifo_empty);
    if (in_reset)
      return WB_SRC_NONE;
    else if (pipe_we)
      return WB_SRC_PIPE;
    else if (!fifo_empty)
      return WB_SRC_FIFO;
    else
      return WB_SRC_NONE;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Multiply/divide result buffer: storage, pointers, occupancy count,
// per-entry valid bits and a parallel destination-compare vector.
//   clk, rst            clock, synchronous active-high reset
//   i_push              store {i_push_addr, i_push_data} at the tail
//   i_pop               retire the head entry
//   o_head_addr/data    oldest buffered result
//   o_empty, o_full     occupancy flags from the registered count
//   i_cmp_rs/rt/rd      decode-stage register addresses to compare
//   o_match             per-entry hit: valid, nonzero, equal to any compare address
module wb_result_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = MD_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [REG_SIZE-1:0]   i_push_addr,
  input  logic [WORD_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [REG_SIZE-1:0]   o_head_addr,
  output logic [WORD_WIDTH-1:0] o_head_data,
  output logic                  o_empty,
  output logic                  o_full,
  input  logic [REG_SIZE-1:0]   i_cmp_rs,
  input  logic [REG_SIZE-1:0]   i_cmp_rt,
  input  logic [REG_SIZE-1:0]   i_cmp_rd,
  output logic [DEPTH-1:0]      o_match
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [REG_SIZE-1:0]   r_addr [DEPTH];
  logic [WORD_WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DEPTH-1:0]      w_valid_nxt;

  assign o_empty     = (r_count == '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign o_head_addr = r_addr[r_rd_ptr];
  assign o_head_data = r_data[r_rd_ptr];

  // Pop clears the head slot before push sets the tail; they never alias
  // because a push is refused when full and a pop needs a non-empty buffer.
  always_comb begin
    w_valid_nxt = r_valid;
    if (i_pop)
      w_valid_nxt[r_rd_ptr] = 1'b0;
    if (i_push)
      w_valid_nxt[r_wr_ptr] = 1'b1;
  end

  always_comb begin
    o_match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      o_match[i] = r_valid[i] && (r_addr[i] != '0) &&
                   ((r_addr[i] == i_cmp_rs) ||
                    (r_addr[i] == i_cmp_rt) ||
                    (r_addr[i] == i_cmp_rd));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      if (i_push) begin
        r_addr[r_wr_ptr] <= i_push_addr;
        r_data[r_wr_ptr] <= i_push_data;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (i_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the MEM/WB write and buffered multiply/divide results onto the
// single register-file write port, and requests a decode stall on hazards.
//   clk, rst                               clock, synchronous active-high reset
//   pipe_weW/pipe_addrW/pipe_dataW         pipeline write request (highest priority)
//   md_valid/md_addr/md_data, md_ready     multiply/divide result handshake
//   id_rs_addr/id_rt_addr/id_rd_addr       decode-stage registers for hazard check
//   stall_req                              decode must hold this cycle
//   md_pending                             buffer non-empty
//   Regfile_weW/writeRegAddrW/writeDataW   register-file write port
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = MD_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_weW,
  input  logic [REG_SIZE-1:0]   pipe_addrW,
  input  logic [WORD_WIDTH-1:0] pipe_dataW,
  input  logic                  md_valid,
  input  logic [REG_SIZE-1:0]   md_addr,
  input  logic [WORD_WIDTH-1:0] md_data,
  output logic                  md_ready,
  input  logic [REG_SIZE-1:0]   id_rs_addr,
  input  logic [REG_SIZE-1:0]   id_rt_addr,
  input  logic [REG_SIZE-1:0]   id_rd_addr,
  output logic                  stall_req,
  output logic                  md_pending,
  output logic                  Regfile_weW,
  output logic [REG_SIZE-1:0]   writeRegAddrW,
  output logic [WORD_WIDTH-1:0] writeDataW
);

  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic [REG_SIZE-1:0]   w_head_addr;
  logic [WORD_WIDTH-1:0] w_head_data;
  logic [FIFO_DEPTH-1:0] w_match;
  wb_src_e               w_src;

  assign md_ready   = !w_full && !rst;
  // r0 results are acknowledged but never occupy a slot.
  assign w_push     = md_valid && md_ready && (md_addr != '0);
  assign w_src      = wb_select(rst, pipe_weW, w_empty);
  assign w_pop      = (w_src == WB_SRC_FIFO);
  assign md_pending = !w_empty && !rst;
  assign stall_req  = !rst && (w_full || (|w_match));

  always_comb begin
    Regfile_weW   = 1'b0;
    writeRegAddrW = '0;
    writeDataW    = ZERO_WORD;
    case (w_src)
      WB_SRC_PIPE: begin
        Regfile_weW   = 1'b1;
        writeRegAddrW = pipe_addrW;
        writeDataW    = pipe_dataW;
      end
      WB_SRC_FIFO: begin
        Regfile_weW   = 1'b1;
        writeRegAddrW = w_head_addr;
        writeDataW    = w_head_data;
      end
      default: ;
    endcase
  end

  wb_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_addr(md_addr),
    .i_push_data(md_data),
    .i_pop      (w_pop),
    .o_head_addr(w_head_addr),
    .o_head_data(w_head_data),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .i_cmp_rs   (id_rs_addr),
    .i_cmp_rt   (id_rt_addr),
    .i_cmp_rd   (id_rd_addr),
    .o_match    (w_match)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  pipe_weW;
  logic [REG_SIZE-1:0]   pipe_addrW;
  logic [WORD_WIDTH-1:0] pipe_dataW;
  logic                  md_valid;
  logic [REG_SIZE-1:0]   md_addr;
  logic [WORD_WIDTH-1:0] md_data;
  logic                  md_ready;
  logic [REG_SIZE-1:0]   id_rs_addr;
  logic [REG_SIZE-1:0]   id_rt_addr;
  logic [REG_SIZE-1:0]   id_rd_addr;
  logic                  stall_req;
  logic                  md_pending;
  logic                  Regfile_weW;
  logic [REG_SIZE-1:0]   writeRegAddrW;
  logic [WORD_WIDTH-1:0] writeDataW;

  always #5 clk = ~clk;

  writeback_arbiter #(
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_weW     (pipe_weW),
    .pipe_addrW   (pipe_addrW),
    .pipe_dataW   (pipe_dataW),
    .md_valid     (md_valid),
    .md_addr      (md_addr),
    .md_data      (md_data),
    .md_ready     (md_ready),
    .id_rs_addr   (id_rs_addr),
    .id_rt_addr   (id_rt_addr),
    .id_rd_addr   (id_rd_addr),
    .stall_req    (stall_req),
    .md_pending   (md_pending),
    .Regfile_weW  (Regfile_weW),
    .writeRegAddrW(writeRegAddrW),
    .writeDataW   (writeDataW)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic [REG_SIZE-1:0]   a;
    logic [WORD_WIDTH-1:0] d;
  } ent_t;

  ent_t mq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic pwe, input logic [REG_SIZE-1:0] pa, input logic [WORD_WIDTH-1:0] pd,
                       input logic mv, input logic [REG_SIZE-1:0] ma, input logic [WORD_WIDTH-1:0] mdv);
    pipe_weW   = pwe;
    pipe_addrW = pa;
    pipe_dataW = pd;
    md_valid   = mv;
    md_addr    = ma;
    md_data    = mdv;
  endtask

  // Called at a falling edge with inputs applied: checks every output against
  // the queue model, then advances the model at the rising edge.
  task automatic cycle();
    logic                  e_full, e_we, e_stall;
    logic [REG_SIZE-1:0]   e_addr;
    logic [WORD_WIDTH-1:0] e_data;
    #1;
    e_full  = (mq.size() == DEPTH);
    e_stall = 1'b0;
    foreach (mq[i])
      if (mq[i].a == id_rs_addr || mq[i].a == id_rt_addr || mq[i].a == id_rd_addr)
        e_stall = 1'b1;
    e_stall = !rst && (e_stall || e_full);
    e_we    = 1'b0;
    e_addr  = '0;
    e_data  = '0;
    if (!rst && pipe_weW) begin
      e_we = 1'b1; e_addr = pipe_addrW; e_data = pipe_dataW;
    end else if (!rst && mq.size() > 0) begin
      e_we = 1'b1; e_addr = mq[0].a; e_data = mq[0].d;
    end
    check_eq("md_ready",   32'(md_ready),      32'(!rst && !e_full));
    check_eq("md_pending", 32'(md_pending),    32'(!rst && mq.size() > 0));
    check_eq("stall_req",  32'(stall_req),     32'(e_stall));
    check_eq("wb_we",      32'(Regfile_weW),   32'(e_we));
    check_eq("wb_addr",    32'(writeRegAddrW), 32'(e_addr));
    check_eq("wb_data",    writeDataW,         e_data);
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (!pipe_weW && mq.size() > 0)
        void'(mq.pop_front());
      if (md_valid && !e_full && md_addr != '0)
        mq.push_back('{a: md_addr, d: md_data});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1;
    id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0;
    drive(1'b1, 5'd3, 32'h1234, 1'b1, 5'd4, 32'h55);
    @(negedge clk);
    cycle();
    cycle();
    #1;
    check_eq("rst_we", 32'(Regfile_weW), 32'd0);
    check_eq("rst_ready", 32'(md_ready), 32'd0);

    // Release reset, idle.
    rst = 1'b0;
    idle(1);
    #1;
    check_eq("idle_ready", 32'(md_ready), 32'd1);

    // Pipe pass-through.
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    #1;
    check_eq("pipe_data", writeDataW, 32'hDEADBEEF);
    cycle();

    // Single multiply/divide result.
    drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h42);
    cycle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    check_eq("md_r9_addr", 32'(writeRegAddrW), 32'd9);
    check_eq("md_r9_pend", 32'(md_pending), 32'd1);
    cycle();
    idle(1);

    // Priority and order: r7 x3 then r3, r4.
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd3, 32'd1); cycle();
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd4, 32'd2); cycle();
    drive(1'b1, 5'd7, 32'h77, 1'b0, '0, '0);      cycle();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    check_eq("order_r3", 32'(writeRegAddrW), 32'd3);
    idle(3);

    // Fill with pipe held, fifth offer refused, then drain.
    for (int unsigned k = 0; k < 5; k++) begin
      drive(1'b1, 5'd1, 32'hA0 + k, 1'b1, 5'(10 + k), 32'h100 + k);
      cycle();
    end
    #1;
    check_eq("full_ready", 32'(md_ready), 32'd0);
    check_eq("full_stall", 32'(stall_req), 32'd1);
    idle(5);

    // Hazard on rt, plus an r0 offer that must not be stored.
    id_rt_addr = 5'd8;
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd8, 32'h88); cycle();
    drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd0, 32'h99); cycle();
    #1;
    check_eq("haz_stall", 32'(stall_req), 32'd1);
    idle(3);
    id_rt_addr = '0;

    // Reset with two entries pending.
    drive(1'b1, 5'd6, 32'h6, 1'b1, 5'd12, 32'hC); cycle();
    drive(1'b1, 5'd6, 32'h6, 1'b1, 5'd13, 32'hD); cycle();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    cycle();
    rst = 1'b0;
    #1;
    check_eq("rst_flush_pend", 32'(md_pending), 32'd0);
    check_eq("rst_flush_we", 32'(Regfile_weW), 32'd0);
    idle(1);

    // Randomized traffic.
    for (int unsigned k = 0; k < 600; k++) begin
      rst        = ($urandom_range(0, 59) == 0);
      id_rs_addr = 5'($urandom_range(0, 7));
      id_rt_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 2) == 0), 5'($urandom), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
